// File: rtl/mpsoc_termination_monitor.sv
// Tracks per-core termination events and exit codes for an N-core MPSoC run,
// with an optional run-cycle watchdog and a post-completion drain window.
module mpsoc_termination_monitor #(
  parameter int NUM_CORES      = 8,
  parameter int XLEN           = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int DRAIN_CYCLES   = 16,
  parameter int IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CORES-1:0]      core_mask,
  input  logic [NUM_CORES-1:0]      term_valid,
  input  logic [NUM_CORES*XLEN-1:0] term_code,
  output logic [NUM_CORES-1:0]      term_mask,
  output logic [NUM_CORES-1:0]      fail_mask,
  output logic [IDX_W-1:0]          first_fail_idx,
  output logic [XLEN-1:0]           first_fail_code,
  output logic [CNT_WIDTH-1:0]      cycle_count,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic                      all_pass,
  output logic [2:0]                dbg_state
);

  localparam int DRW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t                 r_state, w_state_next;
  logic [NUM_CORES-1:0]   r_term_mask, r_fail_mask;
  logic [IDX_W-1:0]       r_ff_idx;
  logic [XLEN-1:0]        r_ff_code;
  logic                   r_ff_captured;
  logic [CNT_WIDTH-1:0]   r_cycle_count;
  logic [DRW-1:0]         r_drain_cnt;

  logic [NUM_CORES-1:0]   w_new_term, w_new_fail, w_term_next;
  logic                   w_complete, w_timeout_hit;
  logic [IDX_W-1:0]       w_ff_idx;
  logic [XLEN-1:0]        w_ff_code;

  // Only first strobes from participating cores count; repeats are ignored.
  assign w_new_term    = core_mask & term_valid & ~r_term_mask;
  assign w_term_next   = r_term_mask | w_new_term;
  assign w_complete    = &(w_term_next | ~core_mask);
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (r_cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_new_fail = '0;
    w_ff_idx   = '0;
    w_ff_code  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_new_fail[i] = w_new_term[i] && (term_code[i*XLEN +: XLEN] != '0);
    end
    // Descending scan so the lowest failing index is the one left standing.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_new_fail[i]) begin
        w_ff_idx  = IDX_W'(i);
        w_ff_code = term_code[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (enable) w_state_next = S_RUN;
      S_RUN: begin
        if (!enable)            w_state_next = S_IDLE;
        else if (w_complete)    w_state_next = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;
        else if (w_timeout_hit) w_state_next = S_TIMEOUT;
      end
      S_DRAIN: begin
        if (!enable)                       w_state_next = S_IDLE;
        else if (r_drain_cnt <= DRW'(1))   w_state_next = S_DONE;
      end
      S_DONE, S_TIMEOUT: if (!enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_term_mask   <= '0;
      r_fail_mask   <= '0;
      r_ff_idx      <= '0;
      r_ff_code     <= '0;
      r_ff_captured <= 1'b0;
      r_cycle_count <= '0;
      r_drain_cnt   <= '0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          r_term_mask   <= '0;
          r_fail_mask   <= '0;
          r_ff_idx      <= '0;
          r_ff_code     <= '0;
          r_ff_captured <= 1'b0;
          r_cycle_count <= '0;
        end
        S_RUN: begin
          r_term_mask <= w_term_next;
          r_fail_mask <= r_fail_mask | w_new_fail;
          if (!r_ff_captured && (w_new_fail != '0)) begin
            r_ff_captured <= 1'b1;
            r_ff_idx      <= w_ff_idx;
            r_ff_code     <= w_ff_code;
          end
          if (~&r_cycle_count) r_cycle_count <= r_cycle_count + 1'b1;
          if (w_complete) r_drain_cnt <= DRW'(DRAIN_CYCLES);
        end
        S_DRAIN: begin
          if (~&r_cycle_count) r_cycle_count <= r_cycle_count + 1'b1;
          r_drain_cnt <= r_drain_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign term_mask       = r_term_mask;
  assign fail_mask       = r_fail_mask;
  assign first_fail_idx  = r_ff_idx;
  assign first_fail_code = r_ff_code;
  assign cycle_count     = r_cycle_count;
  assign busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done            = (r_state == S_DONE);
  assign timeout         = (r_state == S_TIMEOUT);
  assign all_pass        = done && (r_fail_mask == '0);
  assign dbg_state       = r_state;

endmodule

// File: doc/mpsoc_termination_monitor.md
Name: mpsoc_termination_monitor

Overview:
- Synthesizable, parametrised successor to the per-core termination tracking used by the system testbenches.
- Watches per-core termination events and exit codes from N cores, with a per-core participation mask.
- Tracks sticky terminated/failed masks, counts run cycles, and enforces an optional timeout watchdog plus a post-completion drain window.
- Reports done/timeout/pass status. Sits beside the mpsoc top, in simulation or on FPGA, fed by core trace/termination taps.

Parameters:
- NUM_CORES, 8: number of monitored cores (≥1).
- XLEN, 32: exit-code width per core.
- CNT_WIDTH, 32: cycle counter width.
- TIMEOUT_CYCLES, 0: run-cycle limit; 0 disables the watchdog.
- DRAIN_CYCLES, 16: cycles waited after the last core terminates before done asserts.
- IDX_W, max(1,$clog2(NUM_CORES)): width of the core index output.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  start/hold monitoring; low aborts or clears.
- core_mask  in  NUM_CORES  1 = core participates; sampled every cycle.
- term_valid  in  NUM_CORES  per-core termination strobe.
- term_code  in  NUM_CORES*XLEN  exit code of core i in bits [i*XLEN +: XLEN]; valid with term_valid[i].
- term_mask  out  NUM_CORES  sticky: core has terminated.
- fail_mask  out  NUM_CORES  sticky: core terminated with a nonzero code.
- first_fail_idx  out  IDX_W  lowest-index core among the first cycle that recorded a failure.
- first_fail_code  out  XLEN  exit code of that core.
- cycle_count  out  CNT_WIDTH  RUN+DRAIN cycles elapsed; saturating.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- timeout  out  1  state is TIMEOUT.
- all_pass  out  1  done && fail_mask==0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0; internal drain counter 0; first_fail captured flag 0.
- States: IDLE, RUN, DRAIN, DONE, TIMEOUT.
- IDLE:
  - enable=1 -> RUN next cycle.
  - On that transition, clear term_mask, fail_mask, first_fail_*, cycle_count.
- RUN:
  - cycle_count increments each cycle and saturates at all-ones.
  - For each i with core_mask[i] && term_valid[i] && !term_mask[i]: set term_mask[i]; if term_code slice ≠ 0, set fail_mask[i].
  - Repeated strobes are ignored (code not re-sampled). Strobes from masked-off cores are ignored.
  - first_fail_idx/code are captured once: lowest failing index in the first cycle any failure is recorded. Later failures never overwrite them.
  - Completion condition: (term_mask_next | ~core_mask) == all-ones, evaluated including this cycle's updates.
    - DRAIN_CYCLES>0: go to DRAIN and load drain counter with DRAIN_CYCLES.
    - DRAIN_CYCLES==0: go to DONE.
  - core_mask all zero: completion is true on the first RUN cycle.
  - Timeout: TIMEOUT_CYCLES≠0, cycle_count==TIMEOUT_CYCLES-1 and completion false -> TIMEOUT. If completion and timeout occur on the same cycle, completion wins.
- DRAIN:
  - Drain counter decrements each cycle; at 1 -> DONE, so exactly DRAIN_CYCLES cycles are spent in DRAIN.
  - cycle_count keeps counting. Masks are frozen; strobes are ignored. No timeout in DRAIN.
- DONE / TIMEOUT:
  - Sticky; masks, counters and capture outputs are held.
  - enable=0 -> IDLE; outputs hold their values until the next start clears them.
- enable=0 while in RUN or DRAIN -> IDLE next cycle (abort). Masks are held, done/timeout remain 0.
- core_mask changing mid-RUN is legal. Completion is evaluated against the current mask, so de-masking the last pending core completes the run.
- Registered outputs:
  - All outputs update on the clock edge following the causing input.
  - done/timeout assert the cycle after the state transition edge, i.e. they are decoded from the state register.

Test Plan:
- NUM_CORES=4, mask=4'hF, DRAIN_CYCLES=2. term_valid cores 0,1,2,3 on cycles 5,7,7,10, all codes 0 -> term_mask=F, DRAIN for 2 cycles, done=1 and all_pass=1, cycle_count=13 (rising by one per cycle).
- Cores 2 and 1 both fail in the same cycle (codes 0x5, 0x9), core 3 fails later (0x7) -> first_fail_idx=1, first_fail_code=0x9, fail_mask=4'hE, all_pass=0 when done.
- TIMEOUT_CYCLES=100, core 3 never terminates -> timeout=1 with cycle_count=100, done=0, term_mask=4'h7. Variant with core 3 terminating exactly on cycle 99 -> DRAIN, not TIMEOUT.
- Duplicate strobes: core 0 strobes twice, first with code 0 then with code 3 -> fail_mask[0]=0. Strobe from masked-off core 2 (mask=4'hB) -> ignored; run completes without it.
- Edge cases:
  - mask=0 -> done after DRAIN_CYCLES+1 cycles.
  - enable dropped mid-RUN -> IDLE, busy=0.
  - Re-enable -> masks and count cleared.
- rst asserted mid-DRAIN -> all outputs 0 immediately (asynchronously). After release with enable=1 -> RUN on the first clock.
